// File: rtl/queue_burst_drainer_if.sv
// Queue dequeue side plus AW/W/B write channels between the drainer and its neighbours.
// Latency: none, signal bundle only.
// Backpressure: each channel is valid/ready.
interface queue_burst_drainer_if #(
    parameter int DATA_W  = 128,
    parameter int COUNT_W = 8,
    parameter int ADDR_W  = 32
);
    logic               io_deq_ready;
    logic               io_deq_valid;
    logic [DATA_W-1:0]  io_deq_bits;
    logic [COUNT_W-1:0] io_count;

    logic               io_aw_valid;
    logic               io_aw_ready;
    logic [ADDR_W-1:0]  io_aw_addr;
    logic [7:0]         io_aw_len;

    logic               io_w_valid;
    logic               io_w_ready;
    logic [DATA_W-1:0]  io_w_data;
    logic               io_w_last;

    logic               io_b_valid;
    logic               io_b_ready;

    modport master (
        output io_deq_ready,
        input  io_deq_valid, io_deq_bits, io_count,
        output io_aw_valid, io_aw_addr, io_aw_len,
        input  io_aw_ready,
        output io_w_valid, io_w_data, io_w_last,
        input  io_w_ready,
        input  io_b_valid,
        output io_b_ready
    );

    modport slave (
        input  io_deq_ready,
        output io_deq_valid, io_deq_bits, io_count,
        input  io_aw_valid, io_aw_addr, io_aw_len,
        output io_aw_ready,
        input  io_w_valid, io_w_data, io_w_last,
        output io_w_ready,
        output io_b_valid,
        input  io_b_ready
    );
endinterface

// File: rtl/queue_burst_drainer.sv
// Drains a programmed number of queue entries into memory as fixed-size AW/W/B write bursts.
// Latency: start -> 1 WAIT cycle -> AW handshake -> first W beat next cycle, then 1 beat/cycle.
// Backpressure: a burst starts only once the queue holds it all; W stalls follow io_w_ready.
module queue_burst_drainer #(
    parameter int DATA_W    = 128,
    parameter int COUNT_W   = 8,
    parameter int ADDR_W    = 32,
    parameter int BURST_LEN = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_start,
    input  logic [ADDR_W-1:0] io_base_addr,
    input  logic [15:0]       io_total_beats,
    output logic              io_busy,
    output logic              io_done,
    queue_burst_drainer_if.master bus
);
    localparam int BEAT_BYTES = DATA_W / 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ADDR,
        S_DATA,
        S_RESP,
        S_FIN
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       remaining;
    logic [8:0]        cur_len;
    logic [7:0]        beat;

    logic [8:0]        len_nxt;
    logic              count_ok;
    logic              last_beat;
    logic              w_fire;

    // Shorter tail burst once fewer than BURST_LEN entries remain.
    assign len_nxt   = (remaining >= 16'(BURST_LEN)) ? 9'(BURST_LEN) : remaining[8:0];
    assign count_ok  = 17'(bus.io_count) >= 17'(len_nxt);
    assign last_beat = 9'(beat) == (cur_len - 9'd1);
    assign w_fire    = bus.io_deq_valid && bus.io_w_ready;

    assign bus.io_aw_addr = addr;
    assign bus.io_aw_len  = 8'(cur_len - 9'd1);
    assign bus.io_w_data  = bus.io_deq_bits;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        io_busy          = 1'b0;
        io_done          = 1'b0;
        bus.io_deq_ready = 1'b0;
        bus.io_aw_valid  = 1'b0;
        bus.io_w_valid   = 1'b0;
        bus.io_w_last    = 1'b0;
        bus.io_b_ready   = 1'b0;
        case (state)
            S_IDLE: begin
                if (io_start) begin
                    state_nxt = (io_total_beats == 16'd0) ? S_FIN : S_WAIT;
                end
            end
            S_WAIT: begin
                io_busy = 1'b1;
                if (count_ok) begin
                    state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                io_busy         = 1'b1;
                bus.io_aw_valid = 1'b1;
                if (bus.io_aw_ready) begin
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                io_busy          = 1'b1;
                bus.io_w_valid   = bus.io_deq_valid;
                bus.io_deq_ready = bus.io_w_ready;
                bus.io_w_last    = last_beat;
                if (w_fire && last_beat) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                io_busy        = 1'b1;
                bus.io_b_ready = 1'b1;
                if (bus.io_b_valid) begin
                    state_nxt = (remaining == 16'(cur_len)) ? S_FIN : S_WAIT;
                end
            end
            S_FIN: begin
                io_done   = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            addr      <= '0;
            remaining <= '0;
            cur_len   <= 9'd1;
            beat      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (io_start) begin
                        addr      <= io_base_addr;
                        remaining <= io_total_beats;
                    end
                end
                S_WAIT: cur_len <= len_nxt;
                S_ADDR: begin
                    if (bus.io_aw_ready) begin
                        beat <= '0;
                    end
                end
                S_DATA: begin
                    if (w_fire) begin
                        beat <= beat + 8'd1;
                    end
                end
                S_RESP: begin
                    if (bus.io_b_valid) begin
                        remaining <= remaining - 16'(cur_len);
                        addr      <= addr + ADDR_W'(cur_len) * ADDR_W'(BEAT_BYTES);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_queue_burst_drainer.sv
// Directed bench for queue_burst_drainer with a queue model, an AW/W/B monitor and a B responder.
// Latency: checks the start -> AW -> first-beat timing directly.
// Backpressure: exercises random aw/w ready and delayed B responses.
module tb_queue_burst_drainer;
    localparam int DATA_W    = 128;
    localparam int COUNT_W   = 8;
    localparam int ADDR_W    = 32;
    localparam int BURST_LEN = 16;

    logic              clock = 1'b0;
    logic              reset;
    logic              io_start;
    logic [ADDR_W-1:0] io_base_addr;
    logic [15:0]       io_total_beats;
    logic              io_busy;
    logic              io_done;

    always #5 clock = ~clock;

    queue_burst_drainer_if #(.DATA_W(DATA_W), .COUNT_W(COUNT_W), .ADDR_W(ADDR_W)) bus ();

    queue_burst_drainer #(
        .DATA_W(DATA_W), .COUNT_W(COUNT_W), .ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .io_start      (io_start),
        .io_base_addr  (io_base_addr),
        .io_total_beats(io_total_beats),
        .io_busy       (io_busy),
        .io_done       (io_done),
        .bus           (bus)
    );

    function automatic logic [DATA_W-1:0] pat(int i);
        logic [31:0] v;
        v = i;
        return {v ^ 32'hDEADBEEF, v, ~v, v + 32'h100};
    endfunction

    // Queue model: entry with global index i carries pat(i).
    logic [DATA_W-1:0] qmem [256];
    int head = 0;
    int tail = 0;
    assign bus.io_deq_valid = (tail != head);
    assign bus.io_deq_bits  = qmem[8'(head)];
    assign bus.io_count     = COUNT_W'(tail - head);
    always @(posedge clock) begin
        if (bus.io_deq_ready && bus.io_deq_valid) head <= head + 1;
    end

    logic rand_mode = 1'b0;
    logic ready_def = 1'b1;
    always @(posedge clock) begin
        #2;
        if (rand_mode) begin
            bus.io_w_ready  = ($urandom_range(0, 3) != 0);
            bus.io_aw_ready = ($urandom_range(0, 2) == 0);
        end else begin
            bus.io_w_ready  = ready_def;
            bus.io_aw_ready = ready_def;
        end
    end

    int b_delay = 0;
    initial begin
        bus.io_b_valid = 1'b0;
        forever begin
            @(negedge clock);
            if (reset && bus.io_w_valid && bus.io_w_ready && bus.io_w_last) begin
                @(posedge clock);
                repeat (b_delay) @(posedge clock);
                #1 bus.io_b_valid = 1'b1;
                for (int k = 0; k < 1000; k++) begin
                    @(negedge clock);
                    if (bus.io_b_ready) break;
                end
                @(posedge clock);
                #1 bus.io_b_valid = 1'b0;
            end
        end
    end

    // Monitor: handshakes are judged at the negedge before the edge that completes them.
    int aw_cnt = 0, w_cnt = 0, pop_cnt = 0, done_cnt = 0;
    int data_err = 0, aw_unstable = 0, aw_overlap = 0, outstanding = 0;
    logic [ADDR_W-1:0] aw_addr_log [$];
    logic [7:0]        aw_len_log [$];
    int                last_log [$];
    logic              aw_pend = 1'b0;
    logic [ADDR_W-1:0] pend_addr;
    logic [7:0]        pend_len;

    always @(negedge clock) begin
        if (!reset) begin
            outstanding = 0;
            aw_pend     = 1'b0;
        end else begin
            if (aw_pend && !(bus.io_aw_valid && bus.io_aw_addr == pend_addr && bus.io_aw_len == pend_len))
                aw_unstable++;
            aw_pend   = bus.io_aw_valid && !bus.io_aw_ready;
            pend_addr = bus.io_aw_addr;
            pend_len  = bus.io_aw_len;
            if (bus.io_aw_valid && bus.io_aw_ready) begin
                if (outstanding != 0) aw_overlap++;
                outstanding++;
                aw_cnt++;
                aw_addr_log.push_back(bus.io_aw_addr);
                aw_len_log.push_back(bus.io_aw_len);
            end
            if (bus.io_w_valid && bus.io_w_ready) begin
                if (bus.io_w_data !== pat(w_cnt)) data_err++;
                if (bus.io_w_last) last_log.push_back(w_cnt);
                w_cnt++;
            end
            if (bus.io_deq_ready && bus.io_deq_valid) pop_cnt++;
            if (bus.io_b_valid && bus.io_b_ready) outstanding--;
            if (io_done) done_cnt++;
        end
    end

    int n_assert = 0;
    int n_fail   = 0;
    int aw0, w0, p0, l0, d0;

    task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push(int n);
        for (int i = 0; i < n; i++) begin
            qmem[8'(tail)] = pat(tail);
            tail++;
        end
    endtask

    task automatic snap();
        aw0 = aw_cnt; w0 = w_cnt; p0 = pop_cnt; l0 = last_log.size(); d0 = done_cnt;
    endtask

    task automatic do_start(logic [ADDR_W-1:0] base, logic [15:0] total);
        io_base_addr   = base;
        io_total_beats = total;
        io_start       = 1'b1;
        tick(1);
        io_start       = 1'b0;
    endtask

    task automatic wait_done(string tag);
        int dd;
        int n;
        dd = done_cnt;
        n  = 0;
        while (done_cnt == dd && n < 3000) begin
            tick(1);
            n++;
        end
        check(tag, done_cnt - dd, 1);
    endtask

    task automatic check_idle_outputs(string tag);
        check({tag, "_busy"},  io_busy, 0);
        check({tag, "_done"},  io_done, 0);
        check({tag, "_deqr"},  bus.io_deq_ready, 0);
        check({tag, "_awv"},   bus.io_aw_valid, 0);
        check({tag, "_wv"},    bus.io_w_valid, 0);
        check({tag, "_wlast"}, bus.io_w_last, 0);
        check({tag, "_bready"}, bus.io_b_ready, 0);
    endtask

    initial begin
        reset = 1'b0; io_start = 1'b0; io_base_addr = '0; io_total_beats = '0;
        tick(3);
        @(negedge clock);
        check_idle_outputs("rst");
        check("rst_awaddr", bus.io_aw_addr, 0);
        check("rst_awlen",  bus.io_aw_len, 0);
        tick(1);
        reset = 1'b1;
        tick(2);

        // Two full bursts with timing of the first one checked cycle by cycle
        push(32); snap();
        do_start(32'h1000, 16'd32);
        @(negedge clock);
        check("t1_wait_busy", io_busy, 1);
        check("t1_wait_awv", bus.io_aw_valid, 0);
        tick(1);
        @(negedge clock);
        check("t1_awv", bus.io_aw_valid, 1);
        check("t1_awaddr", bus.io_aw_addr, 32'h1000);
        check("t1_awlen", bus.io_aw_len, 15);
        check("t1_wv_early", bus.io_w_valid, 0);
        tick(1);
        @(negedge clock);
        check("t1_wv", bus.io_w_valid, 1);
        check("t1_wdata0", bus.io_w_data, pat(w0));
        check("t1_deqr", bus.io_deq_ready, 1);
        tick(1);
        wait_done("t1_done");
        @(negedge clock);
        check("t1_busy_end", io_busy, 0);
        check("t1_done_one_cycle", io_done, 0);
        check("t1_aw_n", aw_cnt - aw0, 2);
        check("t1_aw1_addr", aw_addr_log[aw0 + 1], 32'h1100);
        check("t1_aw1_len", aw_len_log[aw0 + 1], 15);
        check("t1_pops", pop_cnt - p0, 32);
        check("t1_last_n", last_log.size() - l0, 2);
        check("t1_last0", last_log[l0], w0 + 15);
        check("t1_last1", last_log[l0 + 1], w0 + 31);
        check("t1_data", data_err, 0);
        tick(1);

        // Short tail burst
        push(20); snap();
        do_start(32'h2000, 16'd20);
        wait_done("t2_done");
        check("t2_aw_n", aw_cnt - aw0, 2);
        check("t2_aw0_len", aw_len_log[aw0], 15);
        check("t2_aw1_addr", aw_addr_log[aw0 + 1], 32'h2100);
        check("t2_aw1_len", aw_len_log[aw0 + 1], 3);
        check("t2_last1", last_log[l0 + 1], w0 + 19);
        check("t2_pops", pop_cnt - p0, 20);

        // Slow fill: no AW until the whole burst is queued
        push(10); snap();
        do_start(32'h3000, 16'd16);
        tick(20);
        @(negedge clock);
        check("t3_hold_aw", aw_cnt - aw0, 0);
        check("t3_hold_pops", pop_cnt - p0, 0);
        check("t3_hold_busy", io_busy, 1);
        tick(1);
        push(5);
        tick(5);
        check("t3_15_aw", aw_cnt - aw0, 0);
        push(1);
        wait_done("t3_done");
        check("t3_aw_n", aw_cnt - aw0, 1);
        check("t3_aw_addr", aw_addr_log[aw0], 32'h3000);
        check("t3_pops", pop_cnt - p0, 16);

        // Random ready stalls and slow responses
        push(40); snap();
        rand_mode = 1'b1; b_delay = 5;
        do_start(32'h4000, 16'd40);
        wait_done("t4_done");
        rand_mode = 1'b0; b_delay = 0;
        tick(2);
        check("t4_aw_stable", aw_unstable, 0);
        check("t4_one_outstanding", aw_overlap, 0);
        check("t4_data", data_err, 0);
        check("t4_pops", pop_cnt - p0, 40);
        check("t4_beats", w_cnt - w0, 40);
        check("t4_aw_n", aw_cnt - aw0, 3);
        check("t4_aw1_addr", aw_addr_log[aw0 + 1], 32'h4100);
        check("t4_aw2_addr", aw_addr_log[aw0 + 2], 32'h4200);
        check("t4_aw2_len", aw_len_log[aw0 + 2], 7);
        check("t4_last2", last_log[l0 + 2], w0 + 39);

        // Zero-length job
        snap();
        do_start(32'h5000, 16'd0);
        @(negedge clock);
        check("t5_done", io_done, 1);
        check("t5_busy", io_busy, 0);
        tick(1);
        @(negedge clock);
        check("t5_done_off", io_done, 0);
        check("t5_aw_n", aw_cnt - aw0, 0);
        check("t5_pops", pop_cnt - p0, 0);
        tick(1);

        // Start pulses while busy are ignored
        push(16); snap();
        do_start(32'h6000, 16'd16);
        tick(1);
        do_start(32'h7000, 16'd5);
        tick(3);
        do_start(32'h7000, 16'd5);
        wait_done("t5b_done");
        tick(30);
        check("t5b_aw_n", aw_cnt - aw0, 1);
        check("t5b_aw_addr", aw_addr_log[aw0], 32'h6000);
        check("t5b_pops", pop_cnt - p0, 16);
        check("t5b_done_n", done_cnt - d0, 1);

        // Reset in the middle of a burst, then a clean rerun
        push(16); snap();
        do_start(32'h8000, 16'd16);
        for (int n = 0; n < 200 && (w_cnt - w0) < 5; n++) tick(1);
        check("t6_beats_before_rst", w_cnt - w0, 5);
        reset = 1'b0;
        ready_def = 1'b0;
        tick(1);
        @(negedge clock);
        check_idle_outputs("t6_abort");
        check("t6_queue_kept", bus.io_count, 11);
        tick(1);
        reset = 1'b1;
        ready_def = 1'b1;
        tick(1);
        push(5); snap();
        do_start(32'h9000, 16'd16);
        wait_done("t6_done");
        check("t6_aw_n", aw_cnt - aw0, 1);
        check("t6_aw_addr", aw_addr_log[aw0], 32'h9000);
        check("t6_aw_len", aw_len_log[aw0], 15);
        check("t6_pops", pop_cnt - p0, 16);
        check("t6_last", last_log[l0], w0 + 15);
        check("t6_data", data_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/queue_burst_drainer.md
Name: queue_burst_drainer

Overview:
- Consumer end of the 128-bit synchronous ready/valid queue.
- Drains a programmed number of queue entries and writes them to memory as fixed-size write bursts over an AXI-style AW/W/B channel set.
- Uses the queue occupancy count so that a burst never stalls mid-transfer waiting for data.
- Sits between the 2-port-memory queue dequeue side and the memory write port of the load/store path.

Parameters:
- DATA_W, 128, queue entry width and write beat width
- COUNT_W, 8, width of the queue occupancy count
- ADDR_W, 32, byte address width
- BURST_LEN, 16, maximum beats per burst (1..256, must not exceed queue depth)

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-low reset
- io_start  in  1  one-cycle start pulse; accepted only in IDLE
- io_base_addr  in  ADDR_W  first byte address; caller aligns it to BURST_LEN*DATA_W/8; sampled on accepted start
- io_total_beats  in  16  number of entries to drain; sampled on accepted start
- io_busy  out  1  high from the cycle after an accepted start until done
- io_done  out  1  one-cycle completion pulse
- io_deq_ready  out  1  queue pop
- io_deq_valid  in  1  queue head valid
- io_deq_bits  in  DATA_W  queue head data
- io_count  in  COUNT_W  queue occupancy
- io_aw_valid  out  1  burst address valid
- io_aw_ready  in  1  address accepted
- io_aw_addr  out  ADDR_W  burst start address
- io_aw_len  out  8  beats minus 1
- io_w_valid  out  1  write beat valid
- io_w_ready  in  1  write beat accepted
- io_w_data  out  DATA_W  write beat data
- io_w_last  out  1  final beat of the burst
- io_b_valid  in  1  write response valid
- io_b_ready  out  1  response accept

Behaviour:
- Reset (reset==0 at a clock edge):
  - State goes to IDLE.
  - io_busy, io_done, io_deq_ready, io_aw_valid, io_w_valid, io_w_last and io_b_ready are 0.
  - io_aw_addr and io_aw_len are 0.
  - An abort mid-operation leaves queue contents untouched.
  - Outstanding memory transactions are not tracked after reset.
- Registers:
  - addr: ADDR_W bits, wraps modulo 2^ADDR_W.
  - remaining: 16 bits.
  - cur_len: 9 bits, range 1..256.
  - beat: 8 bits.
- IDLE:
  - On io_start, load addr and remaining from the inputs.
  - If io_total_beats==0, go to FIN; otherwise go to WAIT.
  - io_start is ignored in every other state.
- WAIT:
  - Compute cur_len = min(BURST_LEN, remaining).
  - When io_count >= cur_len, go to ADDR.
  - Evaluate this every cycle; the queue may fill slowly.
- ADDR:
  - io_aw_valid=1, io_aw_addr=addr, io_aw_len=cur_len-1.
  - These outputs hold stable until io_aw_ready.
  - On the handshake, clear beat and go to DATA.
- DATA:
  - Combinational pass-through: io_w_valid=io_deq_valid, io_w_data=io_deq_bits, io_deq_ready=io_w_ready.
  - io_w_last is 1 when beat==cur_len-1.
  - Each cycle with io_deq_valid and io_w_ready: pop one entry and increment beat.
  - On the handshake of the last beat, go to RESP.
  - Outside DATA, io_deq_ready=0 and io_w_valid=0.
- RESP:
  - io_b_ready=1.
  - On io_b_valid: remaining -= cur_len and addr += cur_len*DATA_W/8.
  - Go to FIN if the new remaining==0; otherwise go to WAIT.
  - The response code is not checked.
- FIN:
  - io_done=1 for exactly one cycle, io_busy=0, then go to IDLE.
  - A start arriving during FIN is ignored.
- io_busy is 1 in WAIT, ADDR, DATA and RESP.
- Latency, with ready and count already satisfied:
  - start, then WAIT 1 cycle, then AW handshake in the first ADDR cycle.
  - The first W beat follows on the next cycle.
  - Burst throughput is 1 beat per cycle.
- Only one burst is ever outstanding; AW for burst n+1 is never issued before B for burst n.

Test Plan:
- Queue pre-filled with 32 entries; start with base 0x1000, total 32, BURST_LEN 16, all readies high -> two bursts: AW 0x1000 len 15, then AW 0x1100 len 15; 32 pops in order; w_last on beats 16 and 32; io_done once; io_busy then low.
- total 20 -> bursts of 16 and 4; second AW is addr base+0x100, len 3.
- Queue holds 10 entries, total 16 -> no AW until io_count reaches 16; no pops while waiting.
- Random io_w_ready and io_aw_ready deassertion, with io_b_valid delayed 5 cycles -> AW fields held stable; data order preserved; no beat duplicated or dropped; second AW only after B.
- total 0 -> io_done the cycle after start; no AW and no pop. io_start pulsed while busy -> ignored and totals unaffected.
- reset=0 asserted mid-DATA after 5 beats -> next cycle all valid/ready outputs are 0 and state is IDLE; a new start then runs a full burst correctly.
